// File: rtl/keylock_checker.sv
// -----------------------------------------------------------------------------
// keylock_checker
//
// Consumes digits from the keypad scanner and checks them against a fixed
// combination. One digit is taken per key release (falling edge of bstate).
// A correct entry opens the lock for UNLOCK_CYCLES. Each wrong entry pulses
// fail_pulse. MAX_FAILS consecutive wrong entries put the block into a
// LOCKOUT period of LOCKOUT_CYCLES, during which all key releases are ignored.
//
// Optional feature (macro KEYLOCK_ENTRY_TIMEOUT_EN):
//   When defined, a partial entry is discarded after ENTRY_TIMEOUT idle cycles
//   without a release. This does not count as a failure. When undefined,
//   partial entries persist indefinitely and ENTRY_TIMEOUT is unused.
//
// Ports:
//   hwclk        in   system clock, all logic on posedge
//   rst_n        in   synchronous active-low reset
//   button[3:0]  in   digit code from the scanner, valid around a release
//   bstate       in   key-pressed flag from the scanner
//   unlocked     out  high while the lock is open
//   lockout      out  high while in the lockout period
//   fail_pulse   out  one-cycle pulse per wrong complete entry
//   digit_count  out  digits accepted so far in the current attempt
//   fail_count   out  consecutive failures since last success / lockout end
// -----------------------------------------------------------------------------
module keylock_checker #(
    parameter int                      CODE_LEN       = 4,
    parameter logic [4*CODE_LEN-1:0]   CODE           = 16'h4321,
    parameter logic [31:0]             UNLOCK_CYCLES  = 32'd60000000,
    parameter int                      MAX_FAILS      = 3,
    parameter logic [31:0]             LOCKOUT_CYCLES = 32'd120000000,
    parameter logic [31:0]             ENTRY_TIMEOUT  = 32'd36000000
) (
    input  logic       hwclk,
    input  logic       rst_n,
    input  logic [3:0] button,
    input  logic       bstate,
    output logic       unlocked,
    output logic       lockout,
    output logic       fail_pulse,
    output logic [3:0] digit_count,
    output logic [3:0] fail_count
);

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    state_t      state_reg,       state_next;
    logic        bstate_q_reg;
    logic [3:0]  digit_count_reg, digit_count_next;
    logic        mismatch_reg,    mismatch_next;
    logic [3:0]  fail_count_reg,  fail_count_next;
    logic [31:0] timer_reg,       timer_next;
    logic        fail_pulse_reg,  fail_pulse_next;
    logic        unlocked_reg;
    logic        lockout_reg;

    logic        rel;
    logic        digit_bad;
    logic        entry_bad;

    // Combination unpacked into a 16-entry digit table so it can be indexed
    // directly by the 4-bit digit counter; unused slots read as zero.
    logic [3:0]  code_digit [16];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_code
            if (gi < CODE_LEN) begin : g_used
                assign code_digit[gi] = CODE[4*gi +: 4];
            end else begin : g_pad
                assign code_digit[gi] = 4'h0;
            end
        end
    endgenerate

    // A release is bstate seen high last cycle and low now.
    assign rel       = bstate_q_reg & ~bstate;
    assign digit_bad = (button != code_digit[digit_count_reg]);
    // Final verdict folds the earlier mismatch history into the last compare.
    assign entry_bad = mismatch_reg | digit_bad;

`ifdef KEYLOCK_ENTRY_TIMEOUT_EN
    logic [31:0] idle_reg, idle_next;
`else
    logic unused_entry_timeout;
    assign unused_entry_timeout = ^ENTRY_TIMEOUT;
`endif

    always_comb begin
        state_next       = state_reg;
        digit_count_next = digit_count_reg;
        mismatch_next    = mismatch_reg;
        fail_count_next  = fail_count_reg;
        timer_next       = timer_reg;
        fail_pulse_next  = 1'b0;

        case (state_reg)
            ST_ENTRY: begin
                if (rel) begin
                    if (digit_count_reg != 4'(CODE_LEN - 1)) begin
                        digit_count_next = digit_count_reg + 4'd1;
                        mismatch_next    = entry_bad;
                    end else begin
                        digit_count_next = 4'd0;
                        mismatch_next    = 1'b0;
                        if (!entry_bad) begin
                            state_next      = ST_UNLOCKED;
                            fail_count_next = 4'd0;
                            timer_next      = 32'd0;
                        end else begin
                            fail_pulse_next = 1'b1;
                            if ((fail_count_reg + 4'd1) < 4'(MAX_FAILS)) begin
                                fail_count_next = fail_count_reg + 4'd1;
                            end else begin
                                // Count pins at MAX_FAILS for the whole lockout.
                                fail_count_next = 4'(MAX_FAILS);
                                state_next      = ST_LOCKOUT;
                                timer_next      = 32'd0;
                            end
                        end
                    end
                end
            end
            ST_UNLOCKED: begin
                // Any release relocks at once; the digit is not consumed.
                if (rel || (timer_reg == UNLOCK_CYCLES - 32'd1)) begin
                    state_next = ST_ENTRY;
                    timer_next = 32'd0;
                end else begin
                    timer_next = timer_reg + 32'd1;
                end
            end
            ST_LOCKOUT: begin
                if (timer_reg == LOCKOUT_CYCLES - 32'd1) begin
                    state_next      = ST_ENTRY;
                    fail_count_next = 4'd0;
                    timer_next      = 32'd0;
                end else begin
                    timer_next = timer_reg + 32'd1;
                end
            end
            default: begin
                state_next = ST_ENTRY;
                timer_next = 32'd0;
            end
        endcase

`ifdef KEYLOCK_ENTRY_TIMEOUT_EN
        // Idle counter only runs while a partial entry is pending in ENTRY;
        // a release (or anything else) returns it to zero.
        idle_next = 32'd0;
        if ((state_reg == ST_ENTRY) && (digit_count_reg != 4'd0) && !rel) begin
            if (idle_reg == ENTRY_TIMEOUT - 32'd1) begin
                digit_count_next = 4'd0;
                mismatch_next    = 1'b0;
            end else begin
                idle_next = idle_reg + 32'd1;
            end
        end
`endif
    end

    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            state_reg       <= ST_ENTRY;
            bstate_q_reg    <= 1'b0;
            digit_count_reg <= 4'd0;
            mismatch_reg    <= 1'b0;
            fail_count_reg  <= 4'd0;
            timer_reg       <= 32'd0;
            fail_pulse_reg  <= 1'b0;
            unlocked_reg    <= 1'b0;
            lockout_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bstate_q_reg    <= bstate;
            digit_count_reg <= digit_count_next;
            mismatch_reg    <= mismatch_next;
            fail_count_reg  <= fail_count_next;
            timer_reg       <= timer_next;
            fail_pulse_reg  <= fail_pulse_next;
            unlocked_reg    <= (state_next == ST_UNLOCKED);
            lockout_reg     <= (state_next == ST_LOCKOUT);
        end
    end

`ifdef KEYLOCK_ENTRY_TIMEOUT_EN
    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            idle_reg <= 32'd0;
        end else begin
            idle_reg <= idle_next;
        end
    end
`endif

    assign unlocked    = unlocked_reg;
    assign lockout     = lockout_reg;
    assign fail_pulse  = fail_pulse_reg;
    assign digit_count = digit_count_reg;
    assign fail_count  = fail_count_reg;

endmodule

// File: tb/tb_keylock_checker.sv
// -----------------------------------------------------------------------------
// Testbench for keylock_checker: a table of four-digit entries with expected
// verdicts, followed by hand-written sequences for lockout, early relock,
// reset mid-operation and the entry timeout.
// -----------------------------------------------------------------------------
module tb_keylock_checker;

    logic       hwclk;
    logic       rst_n;
    logic [3:0] button;
    logic       bstate;
    logic       unlocked;
    logic       lockout;
    logic       fail_pulse;
    logic [3:0] digit_count;
    logic [3:0] fail_count;

    int tests_run  = 0;
    int tests_fail = 0;

    // values observed one tick after a release, and one tick later still
    logic       rel_unl, rel_lo, rel_fp, fp_after;
    logic [3:0] rel_dc, rel_fc;

    keylock_checker #(
        .CODE_LEN      (4),
        .CODE          (16'h4321),
        .UNLOCK_CYCLES (32'd100),
        .MAX_FAILS     (3),
        .LOCKOUT_CYCLES(32'd200),
        .ENTRY_TIMEOUT (32'd50)
    ) dut (
        .hwclk      (hwclk),
        .rst_n      (rst_n),
        .button     (button),
        .bstate     (bstate),
        .unlocked   (unlocked),
        .lockout    (lockout),
        .fail_pulse (fail_pulse),
        .digit_count(digit_count),
        .fail_count (fail_count)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] digits;   // first-entered digit in [3:0]
        logic        exp_unl;
        logic        exp_fp;
        logic [3:0]  exp_fc;
    } vec_t;

    vec_t vecs [9];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge hwclk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // bstate high 5 cycles then low 10; captures outputs right after release
    task automatic press(input logic [3:0] d);
        button = d;
        bstate = 1'b1;
        tick(5);
        bstate = 1'b0;
        tick(1);
        rel_unl = unlocked;
        rel_lo  = lockout;
        rel_fp  = fail_pulse;
        rel_dc  = digit_count;
        rel_fc  = fail_count;
        tick(1);
        fp_after = fail_pulse;
        tick(8);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        tick(2);
        rst_n  = 1'b1;
        tick(1);
    endtask

    initial begin
        vecs[0] = '{16'h4321, 1'b1, 1'b0, 4'd0};
        vecs[1] = '{16'h5321, 1'b0, 1'b1, 4'd1};
        vecs[2] = '{16'h4321, 1'b1, 1'b0, 4'd0};
        vecs[3] = '{16'h1234, 1'b0, 1'b1, 4'd1};
        vecs[4] = '{16'hA321, 1'b0, 1'b1, 4'd2};
        vecs[5] = '{16'h4321, 1'b1, 1'b0, 4'd0};
        vecs[6] = '{16'h432F, 1'b0, 1'b1, 4'd1};
        vecs[7] = '{16'h43F1, 1'b0, 1'b1, 4'd2};
        vecs[8] = '{16'h4321, 1'b1, 1'b0, 4'd0};

        rst_n  = 1'b0;
        bstate = 1'b0;
        button = 4'd0;
        tick(3);
        check("reset_unlocked", 32'(unlocked), 32'd0);
        check("reset_lockout", 32'(lockout), 32'd0);
        check("reset_fail_pulse", 32'(fail_pulse), 32'd0);
        check("reset_digit_count", 32'(digit_count), 32'd0);
        check("reset_fail_count", 32'(fail_count), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // ---- table-driven entries ----
        for (int v = 0; v < 9; v++) begin
            for (int j = 0; j < 4; j++) begin
                press(vecs[v].digits[4*j +: 4]);
                if (j < 3)
                    check($sformatf("v%0d_digit_count_%0d", v, j), 32'(rel_dc), 32'(j + 1));
            end
            check($sformatf("v%0d_digit_count_final", v), 32'(rel_dc), 32'd0);
            check($sformatf("v%0d_unlocked", v), 32'(rel_unl), 32'(vecs[v].exp_unl));
            check($sformatf("v%0d_fail_pulse", v), 32'(rel_fp), 32'(vecs[v].exp_fp));
            check($sformatf("v%0d_fail_pulse_clear", v), 32'(fp_after), 32'd0);
            check($sformatf("v%0d_fail_count", v), 32'(rel_fc), 32'(vecs[v].exp_fc));
            check($sformatf("v%0d_lockout", v), 32'(rel_lo), 32'd0);
            $display("[TB] entry %0d digits=%h unlocked=%0d fail_pulse=%0d fail_count=%0d",
                     v, vecs[v].digits, rel_unl, rel_fp, rel_fc);
            if (vecs[v].exp_unl) begin
                // 9 ticks elapsed since unlock (k=9); high through k=99, low at k=100
                tick(90);
                check($sformatf("v%0d_unlock_held", v), 32'(unlocked), 32'd1);
                tick(1);
                check($sformatf("v%0d_unlock_expired", v), 32'(unlocked), 32'd0);
                tick(4);
            end
        end

        // ---- early relock ----
        do_reset();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("early_unlocked", 32'(rel_unl), 32'd1);
        tick(5);                                   // k=14
        check("early_still_open", 32'(unlocked), 32'd1);
        press(4'd7);                               // release at k=20
        check("early_relock", 32'(rel_unl), 32'd0);
        check("early_digit_count", 32'(rel_dc), 32'd0);
        $display("[TB] early relock unlocked=%0d digit_count=%0d", rel_unl, rel_dc);

        // ---- lockout ----
        do_reset();
        for (int a = 0; a < 3; a++) begin
            for (int j = 0; j < 4; j++) press(4'd9);
            check($sformatf("lock_fp_%0d", a), 32'(rel_fp), 32'd1);
            check($sformatf("lock_state_%0d", a), 32'(rel_lo), (a == 2) ? 32'd1 : 32'd0);
            check($sformatf("lock_fc_%0d", a), 32'(rel_fc), 32'(a + 1));
        end
        // k=9 into lockout; four presses ignored
        for (int j = 0; j < 4; j++) begin
            press(4'(j + 1));
            check($sformatf("lock_ignore_dc_%0d", j), 32'(rel_dc), 32'd0);
            check($sformatf("lock_ignore_fp_%0d", j), 32'(rel_fp), 32'd0);
        end
        check("lock_ignore_unl", 32'(unlocked), 32'd0);
        tick(130);                                 // k=199
        check("lock_held", 32'(lockout), 32'd1);
        check("lock_fc_sat", 32'(fail_count), 32'd3);
        tick(1);                                   // k=200
        check("lock_end", 32'(lockout), 32'd0);
        check("lock_end_fc", 32'(fail_count), 32'd0);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("lock_after_unlock", 32'(rel_unl), 32'd1);
        $display("[TB] lockout sequence done unlocked=%0d", rel_unl);

        // ---- reset mid-entry ----
        do_reset();
        press(4'd1); press(4'd2);
        check("rst_pre_dc", 32'(digit_count), 32'd2);
        rst_n = 1'b0;
        tick(1);
        check("rst_mid_dc", 32'(digit_count), 32'd0);
        check("rst_mid_unl", 32'(unlocked), 32'd0);
        check("rst_mid_fp", 32'(fail_pulse), 32'd0);
        rst_n = 1'b1;
        tick(1);
        press(4'd3);
        check("rst_restart_dc3", 32'(rel_dc), 32'd1);
        press(4'd4);
        check("rst_restart_dc4", 32'(rel_dc), 32'd2);
        check("rst_restart_unl", 32'(rel_unl), 32'd0);
        $display("[TB] reset mid-entry digit_count=%0d unlocked=%0d", rel_dc, rel_unl);

        // ---- reset during lockout ----
        do_reset();
        for (int a = 0; a < 3; a++)
            for (int j = 0; j < 4; j++) press(4'd9);
        check("rstlo_lockout", 32'(lockout), 32'd1);
        rst_n = 1'b0;
        tick(1);
        check("rstlo_cleared", 32'(lockout), 32'd0);
        check("rstlo_fc", 32'(fail_count), 32'd0);
        rst_n = 1'b1;
        tick(1);
        $display("[TB] reset during lockout lockout=%0d", lockout);

        // ---- entry timeout ----
        do_reset();
        press(4'd1); press(4'd2);                  // R+9 after second release
`ifdef KEYLOCK_ENTRY_TIMEOUT_EN
        tick(40);                                  // R+49
        check("to_before", 32'(digit_count), 32'd2);
        tick(1);                                   // R+50
        check("to_cleared", 32'(digit_count), 32'd0);
        check("to_no_fp", 32'(fail_pulse), 32'd0);
        check("to_fc", 32'(fail_count), 32'd0);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("to_unlock", 32'(rel_unl), 32'd1);
`else
        tick(1000);
        check("noto_kept", 32'(digit_count), 32'd2);
        press(4'd3); press(4'd4);
        check("noto_unlock", 32'(rel_unl), 32'd1);
        check("noto_fc", 32'(rel_fc), 32'd0);
`endif
        $display("[TB] timeout sequence unlocked=%0d", rel_unl);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule

// File: doc/keylock_checker.md
Name: keylock_checker

Overview:
- Consumer side of the keypad scanner's `button`/`bstate` interface.
- Accepts one digit per key release, meaning a falling edge of `bstate`.
- Compares the entered sequence against a fixed combination and drives the lock output.
- Tracks failed attempts and enters a timed lockout after too many failures; sits between the keypad scanner and the lock actuator/LEDs.

Parameters:
- CODE_LEN, 4, digits per combination (1..15).
- CODE, 16'h4321, packed combination, 4 bits per digit; digit 0 (first entered) in bits [3:0]; width 4*CODE_LEN.
- UNLOCK_CYCLES, 32'd60000000, hwclk cycles `unlocked` stays high (5 s at 12 MHz).
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout (1..15).
- LOCKOUT_CYCLES, 32'd120000000, hwclk cycles of lockout (10 s).
- ENTRY_TIMEOUT, 32'd36000000, idle cycles before a partial entry is discarded (optional feature only).

Ports:
- hwclk, input, 1, system clock (12 MHz); all logic on posedge.
- rst_n, input, 1, synchronous active-low reset.
- button, input, 4, digit code from keypad scanner; valid while/after `bstate` high.
- bstate, input, 1, key-pressed flag from scanner; a falling edge marks a release.
- unlocked, output, 1, high while in UNLOCKED.
- lockout, output, 1, high while in LOCKOUT.
- fail_pulse, output, 1, one-cycle pulse on each wrong complete entry.
- digit_count, output, 4, digits accepted in the current attempt.
- fail_count, output, 4, consecutive failures since the last success or lockout end.

Behaviour:
- **Reset** (rst_n low at posedge): state=ENTRY; all outputs 0; counters 0; mismatch flag 0; `bstate_q` 0.
- **Release detect:**
  - `bstate_q` registers `bstate` every cycle; `rel = bstate_q & ~bstate`.
  - The digit is `button` sampled in the same cycle as `rel`.
  - `rel` is the only event that consumes a digit; no pulse is missed when releases are one cycle apart.
- **ENTRY state, on `rel`:**
  - Compare the digit with `CODE[4*digit_count +: 4]`.
  - If it differs, set `mismatch`.
  - If `digit_count < CODE_LEN-1`: `digit_count++`.
  - If `digit_count == CODE_LEN-1` (final digit): evaluate `ok = ~mismatch & (digit == CODE digit)`, using the pre-update mismatch OR-ed with the final compare. Clear `digit_count` and `mismatch` in the same cycle.
    - `ok`: go to UNLOCKED next cycle; `unlocked=1` from that cycle; `fail_count=0`; timer=0.
    - `!ok` and `fail_count+1 < MAX_FAILS`: `fail_pulse=1` for one cycle; `fail_count++`; stay in ENTRY.
    - `!ok` and `fail_count+1 == MAX_FAILS`: `fail_pulse=1`; go to LOCKOUT; `lockout=1` next cycle; timer=0.
- **UNLOCKED state:**
  - Timer increments every cycle; at `timer == UNLOCK_CYCLES-1` go to ENTRY with `unlocked=0` next cycle.
  - A `rel` in UNLOCKED relocks immediately: ENTRY next cycle, no digit consumed.
- **LOCKOUT state:**
  - All `rel` ignored (no `digit_count` change, no `fail_pulse`).
  - At `timer == LOCKOUT_CYCLES-1`: go to ENTRY; `fail_count=0`; `lockout=0` next cycle.
- **Latency:** outputs registered; final-digit release to `unlocked`/`lockout`/`fail_pulse` high is exactly 1 cycle.
- **Other rules:**
  - `fail_count` saturates at MAX_FAILS; never wraps.
  - Timers are 32-bit; compare by equality against param-1; no wrap reachable.
  - Reset mid-attempt or mid-lockout returns everything to reset values on that edge; a `rel` in the reset cycle is ignored.
  - `button` values 10–15 are accepted as digits and compared normally; they simply mismatch when CODE holds 0–9.

Optional Feature:
- Macro: `KEYLOCK_ENTRY_TIMEOUT_EN`.
- **Defined:**
  - In ENTRY with `digit_count != 0`, an idle counter increments each cycle without `rel` and clears on `rel`.
  - At `idle == ENTRY_TIMEOUT-1`: `digit_count=0`, `mismatch=0`. No `fail_pulse`; `fail_count` unchanged.
  - The counter is held at 0 when `digit_count == 0` or state != ENTRY.
- **Undefined:** no idle counter; partial entries persist indefinitely; ENTRY_TIMEOUT unused.

Test Plan:
- Setup for all tests: CODE_LEN=4, CODE=16'h4321, MAX_FAILS=3, UNLOCK_CYCLES=100, LOCKOUT_CYCLES=200, ENTRY_TIMEOUT=50. Each press is `bstate` 1 for 5 cycles, then 0 for 10.
- **Correct code:** press/release 1,2,3,4 -> `digit_count` steps 1,2,3,0; `unlocked=1` one cycle after 4th release; held 100 cycles, then 0; `fail_count=0`.
- **Wrong code:** press/release 1,2,3,5 -> `fail_pulse` one cycle; `fail_count=1`; `unlocked` stays 0. Then 1,2,3,4 -> unlocked, `fail_count=0`.
- **Lockout:** three wrong entries (9,9,9,9) -> `fail_pulse` x3; `lockout=1` after the third. Entering 1,2,3,4 during lockout -> no effect, `digit_count` stays 0. After 200 cycles `lockout=0`, `fail_count=0`; next correct entry unlocks.
- **Early relock:** unlock, then release any key at cycle 20 of UNLOCKED -> `unlocked=0` next cycle; `digit_count` stays 0.
- **Reset mid-operation:** after entering 1,2, pulse rst_n low one cycle -> all outputs 0. Then 3,4 do not unlock (count restarts). Also reset during lockout -> `lockout=0` immediately.
- **Timeout (`KEYLOCK_ENTRY_TIMEOUT_EN` defined):** enter 1,2 then idle 50 cycles -> `digit_count=0`, no `fail_pulse`; then 1,2,3,4 unlocks. Without the macro: enter 1,2, idle 1000 cycles, then 3,4 -> unlocks.
